// File: rtl/ub_pkg.sv
// Shared types and address helpers for the banked raster unified buffer.
package ub_pkg;

    // Widest raster coordinate carried in the shared position struct.
    localparam int unsigned PosW = 16;

    typedef struct packed {
        logic [PosW-1:0] x;
        logic [PosW-1:0] y;
        logic            phase;
    } raster_pos_t;

    // clog2 clamped to at least one bit so single-entry fields stay legal.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bank index: (x mod banks_x) + banks_x * (y mod banks_y), as masks and shifts.
    function automatic int unsigned bank_of(input int unsigned x, input int unsigned y,
                                            input int unsigned banks_x,
                                            input int unsigned banks_y);
        return (x & (banks_x - 1)) | ((y & (banks_y - 1)) << $clog2(banks_x));
    endfunction

    // In-bank word: (x / banks_x) + (dim_x / banks_x) * (y / banks_y), as shifts.
    function automatic int unsigned bank_addr(input int unsigned x, input int unsigned y,
                                              input int unsigned dim_x,
                                              input int unsigned banks_x,
                                              input int unsigned banks_y);
        return (x >> $clog2(banks_x)) |
               ((y >> $clog2(banks_y)) << ($clog2(dim_x) - $clog2(banks_x)));
    endfunction

endpackage

// File: rtl/ub_raster_counter.sv
// Raster (x, y, phase) position generator with a registered end-of-frame pulse.
module ub_raster_counter
    import ub_pkg::*;
#(
    parameter int unsigned DIM_X = 64,
    parameter int unsigned DIM_Y = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        inc,
    input  logic                        clr,
    output logic [clog2w(DIM_X)-1:0]    x,
    output logic [clog2w(DIM_Y)-1:0]    y,
    output logic                        phase,
    output logic                        wrap
);

    localparam int unsigned XW = clog2w(DIM_X);
    localparam int unsigned YW = clog2w(DIM_Y);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          phase_q, phase_d;
    logic          wrap_q, wrap_d;

    // Next position: clear wins, otherwise step x, carry into y, toggle phase at frame end.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (clr) begin
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
        end else if (inc) begin
            if (x_q == XW'(DIM_X - 1)) begin
                x_d = '0;
                if (y_q == YW'(DIM_Y - 1)) begin
                    y_d     = '0;
                    phase_d = ~phase_q;
                    wrap_d  = 1'b1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/ub_banked_raster.sv
// Banked unified buffer for one 2-D stencil with raster-ordered write and read ports.
module ub_banked_raster
    import ub_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DIM_X   = 64,
    parameter int unsigned DIM_Y   = 64,
    parameter int unsigned BANKS_X = 2,
    parameter int unsigned BANKS_Y = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic                                rd_req,
    output logic                                rd_ready,
    output logic [DATA_W-1:0]                   rd_data,
    output logic                                rd_valid,
    output logic [$clog2(DIM_X*DIM_Y+1)-1:0]    occupancy,
    output logic                                wr_frame_done,
    output logic                                rd_frame_done
);

    localparam int unsigned XW         = clog2w(DIM_X);
    localparam int unsigned YW         = clog2w(DIM_Y);
    localparam int unsigned NBANKS     = BANKS_X * BANKS_Y;
    localparam int unsigned BANK_W     = clog2w(NBANKS);
    localparam int unsigned BANK_DEPTH = (DIM_X * DIM_Y) / NBANKS;
    localparam int unsigned ADDR_W     = clog2w(BANK_DEPTH);
    localparam int unsigned OCC_W      = $clog2(DIM_X * DIM_Y + 1);

    logic [XW-1:0]     wr_x, rd_x;
    logic [YW-1:0]     wr_y, rd_y;
    logic              wr_phase, rd_phase;
    raster_pos_t       wr_pos, rd_pos;
    logic              same_xy, empty, full;
    logic              wr_acc, rd_acc;
    logic [BANK_W-1:0] wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] bank_rdata [NBANKS];
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Occupancy state and accept qualification.
    always_comb begin
        wr_pos  = '{x: PosW'(wr_x), y: PosW'(wr_y), phase: wr_phase};
        rd_pos  = '{x: PosW'(rd_x), y: PosW'(rd_y), phase: rd_phase};
        same_xy = (wr_pos.x == rd_pos.x) && (wr_pos.y == rd_pos.y);
        empty   = same_xy && (wr_pos.phase == rd_pos.phase);
        full    = same_xy && (wr_pos.phase != rd_pos.phase);
        rd_acc  = rd_req && !empty && !flush;
        // A full buffer still takes a write alongside a read: the slot being read is reused
        // at once (read-before-write), keeping one-per-cycle flow in the full steady state.
        wr_acc  = wr_valid && (!full || rd_acc) && !flush;
    end

    assign wr_ready = !full;
    assign rd_ready = !empty;

    ub_raster_counter #(
        .DIM_X (DIM_X),
        .DIM_Y (DIM_Y)
    ) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc),
        .clr   (flush),
        .x     (wr_x),
        .y     (wr_y),
        .phase (wr_phase),
        .wrap  (wr_frame_done)
    );

    ub_raster_counter #(
        .DIM_X (DIM_X),
        .DIM_Y (DIM_Y)
    ) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc),
        .clr   (flush),
        .x     (rd_x),
        .y     (rd_y),
        .phase (rd_phase),
        .wrap  (rd_frame_done)
    );

    // Cyclic bank interleave for both ports.
    always_comb begin
        wr_bank = BANK_W'(bank_of(32'(wr_x), 32'(wr_y), BANKS_X, BANKS_Y));
        rd_bank = BANK_W'(bank_of(32'(rd_x), 32'(rd_y), BANKS_X, BANKS_Y));
        wr_addr = ADDR_W'(bank_addr(32'(wr_x), 32'(wr_y), DIM_X, BANKS_X, BANKS_Y));
        rd_addr = ADDR_W'(bank_addr(32'(rd_x), 32'(rd_y), DIM_X, BANKS_X, BANKS_Y));
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [DATA_W-1:0] bank_mem [BANK_DEPTH];
        logic              we;

        assign we = wr_acc && (wr_bank == BANK_W'(b));

        // Bank storage: unreset, survives flush.
        always_ff @(posedge clk) begin
            if (we) begin
                bank_mem[wr_addr] <= wr_data;
            end
        end

        assign bank_rdata[b] = bank_mem[rd_addr];
    end

    assign rd_word = bank_rdata[rd_bank];

    // Read register, valid flag and occupancy next-state; flush discards this cycle's accepts.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        occ_d      = occ_q;
        if (rd_acc) begin
            rd_data_d = rd_word;
        end
        if (flush) begin
            occ_d = '0;
        end else if (wr_acc && !rd_acc) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (rd_acc && !wr_acc) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Output and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            occ_q      <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            occ_q      <= occ_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_ub_banked_raster.sv
// Directed bench for ub_banked_raster at 4x4 words in 2x2 banks.
module tb_ub_banked_raster;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [4:0]  occupancy;
    logic        wr_frame_done;
    logic        rd_frame_done;

    int n_run  = 0;
    int n_fail = 0;

    ub_banked_raster #(
        .DATA_W  (16),
        .DIM_X   (4),
        .DIM_Y   (4),
        .BANKS_X (2),
        .BANKS_Y (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req        (rd_req),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .occupancy     (occupancy),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic        rr;
        logic        e_wrdy;
        logic        e_rrdy;
        logic        e_rv;
        logic [15:0] e_rd;
        int          e_occ;
        logic        e_wfd;
        logic        e_rfd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int wv, input int wd, input int rr, input int e_wrdy,
                                input int e_rrdy, input int e_rv, input int e_rd,
                                input int e_occ, input int e_wfd, input int e_rfd);
        vec_t v;
        v.wv     = wv[0];
        v.wd     = wd[15:0];
        v.rr     = rr[0];
        v.e_wrdy = e_wrdy[0];
        v.e_rrdy = e_rrdy[0];
        v.e_rv   = e_rv[0];
        v.e_rd   = e_rd[15:0];
        v.e_occ  = e_occ;
        v.e_wfd  = e_wfd[0];
        v.e_rfd  = e_rfd[0];
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        wr_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(base + i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " wr_ready"},      32'(wr_ready),      32'd1);
        check({tag, " rd_ready"},      32'(rd_ready),      32'd0);
        check({tag, " rd_valid"},      32'(rd_valid),      32'd0);
        check({tag, " rd_data"},       32'(rd_data),       32'd0);
        check({tag, " occupancy"},     32'(occupancy),     32'd0);
        check({tag, " wr_frame_done"}, 32'(wr_frame_done), 32'd0);
        check({tag, " rd_frame_done"}, 32'(rd_frame_done), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_b0 [4];
        logic [15:0] exp_b3 [4];
        exp_b0 = '{16'd0, 16'd2, 16'd8, 16'd10};
        exp_b3 = '{16'd5, 16'd7, 16'd13, 16'd15};

        // Raster order table: outputs listed are those seen before each vector's edge.
        for (int i = 0; i < 16; i++) add(1, i, 0, 1, (i > 0) ? 1 : 0, 0, 0, i, 0, 0);
        add(1, 999, 0, 0, 1, 0, 0, 16, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 16, 0, 0);
        for (int j = 0; j < 16; j++)
            add(0, 0, 1, (j > 0) ? 1 : 0, 1, (j > 0) ? 1 : 0, (j > 0) ? j - 1 : 0, 16 - j, 0, 0);
        add(0, 0, 0, 1, 0, 1, 15, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 15, 0, 0, 0);

        do_reset();
        check_reset_vals("reset");
        for (int k = 0; k < vecs.size(); k++) begin
            wr_valid = vecs[k].wv;
            wr_data  = vecs[k].wd;
            rd_req   = vecs[k].rr;
            check($sformatf("v%0d wr_ready", k),      32'(wr_ready),      32'(vecs[k].e_wrdy));
            check($sformatf("v%0d rd_ready", k),      32'(rd_ready),      32'(vecs[k].e_rrdy));
            check($sformatf("v%0d rd_valid", k),      32'(rd_valid),      32'(vecs[k].e_rv));
            if (vecs[k].e_rv)
                check($sformatf("v%0d rd_data", k),   32'(rd_data),       32'(vecs[k].e_rd));
            check($sformatf("v%0d occupancy", k),     32'(occupancy),     32'(vecs[k].e_occ));
            check($sformatf("v%0d wr_frame_done", k), 32'(wr_frame_done), 32'(vecs[k].e_wfd));
            check($sformatf("v%0d rd_frame_done", k), 32'(rd_frame_done), 32'(vecs[k].e_rfd));
            step();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;

        // Bank mapping probe.
        for (int a = 0; a < 4; a++) begin
            check($sformatf("bank0[%0d]", a), 32'(dut.g_bank[0].bank_mem[a]), 32'(exp_b0[a]));
            check($sformatf("bank3[%0d]", a), 32'(dut.g_bank[3].bank_mem[a]), 32'(exp_b3[a]));
        end

        // Full buffer, ignored write, then read+write in one cycle.
        do_reset();
        write_n(16, 200);
        check("full wr_ready", 32'(wr_ready), 32'd0);
        check("full occupancy", 32'(occupancy), 32'd16);
        wr_valid = 1'b1;
        wr_data  = 16'd999;
        step();
        check("ignored occupancy", 32'(occupancy), 32'd16);
        check("ignored bank0[0]", 32'(dut.g_bank[0].bank_mem[0]), 32'd200);
        wr_data = 16'd555;
        rd_req  = 1'b1;
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        check("pair rd_valid", 32'(rd_valid), 32'd1);
        check("pair rd_data", 32'(rd_data), 32'd200);
        check("pair occupancy", 32'(occupancy), 32'd16);
        check("pair wr_ready", 32'(wr_ready), 32'd0);
        check("pair bank0[0]", 32'(dut.g_bank[0].bank_mem[0]), 32'd555);

        // Empty: requests ignored, then write-to-read latency.
        do_reset();
        rd_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("empty%0d rd_valid", c), 32'(rd_valid), 32'd0);
            check($sformatf("empty%0d occupancy", c), 32'(occupancy), 32'd0);
        end
        wr_valid = 1'b1;
        wr_data  = 16'd77;
        step();
        wr_valid = 1'b0;
        check("lat N+1 rd_ready", 32'(rd_ready), 32'd1);
        check("lat N+1 rd_valid", 32'(rd_valid), 32'd0);
        step();
        rd_req = 1'b0;
        check("lat N+2 rd_valid", 32'(rd_valid), 32'd1);
        check("lat N+2 rd_data", 32'(rd_data), 32'd77);
        step();
        check("lat N+3 rd_valid", 32'(rd_valid), 32'd0);
        check("lat N+3 rd_data hold", 32'(rd_data), 32'd77);

        // Flush mid-frame with accepts offered in the flush cycle.
        do_reset();
        write_n(6, 300);
        rd_req = 1'b1;
        step();
        step();
        check("pre-flush occupancy", 32'(occupancy), 32'd4);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'd888;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        check("flush occupancy", 32'(occupancy), 32'd0);
        check("flush rd_ready", 32'(rd_ready), 32'd0);
        check("flush wr_ready", 32'(wr_ready), 32'd1);
        check("flush rd_valid", 32'(rd_valid), 32'd0);
        check("flush rd_data hold", 32'(rd_data), 32'd301);
        wr_valid = 1'b1;
        wr_data  = 16'd400;
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        check("post-flush occupancy", 32'(occupancy), 32'd1);
        step();
        rd_req = 1'b0;
        check("post-flush rd_valid", 32'(rd_valid), 32'd1);
        check("post-flush rd_data", 32'(rd_data), 32'd400);
        check("post-flush bank0[0]", 32'(dut.g_bank[0].bank_mem[0]), 32'd400);

        // Asynchronous reset between edges with occupancy 9.
        do_reset();
        write_n(10, 500);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("pre-reset occupancy", 32'(occupancy), 32'd9);
        check("pre-reset rd_data", 32'(rd_data), 32'd500);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        step();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
